// File: rtl/fft_4x4_2d_stream_if.sv
// Row-in / row-out handshake bundle for fft_4x4_2d_stream; OUT_W tracks the FFT_SCALE_EN build macro.
// master = upstream/downstream side (drives rows in, accepts rows out); slave = the transform block.
interface fft_4x4_2d_stream_if #(
    parameter int DATA_W = 16
);
`ifdef FFT_SCALE_EN
    localparam int OUT_W = DATA_W;
`else
    localparam int OUT_W = DATA_W + 4;
`endif

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] din_real_0, din_real_1, din_real_2, din_real_3;
    logic signed [DATA_W-1:0] din_imag_0, din_imag_1, din_imag_2, din_imag_3;
    logic                     out_valid;
    logic                     out_ready;
    logic [1:0]               out_row;
    logic                     out_last;
    logic signed [OUT_W-1:0]  dout_real_0, dout_real_1, dout_real_2, dout_real_3;
    logic signed [OUT_W-1:0]  dout_imag_0, dout_imag_1, dout_imag_2, dout_imag_3;
    logic                     done;

    modport master (
        output in_valid, din_real_0, din_real_1, din_real_2, din_real_3,
               din_imag_0, din_imag_1, din_imag_2, din_imag_3, out_ready,
        input  in_ready, out_valid, out_row, out_last, done,
               dout_real_0, dout_real_1, dout_real_2, dout_real_3,
               dout_imag_0, dout_imag_1, dout_imag_2, dout_imag_3
    );

    modport slave (
        input  in_valid, din_real_0, din_real_1, din_real_2, din_real_3,
               din_imag_0, din_imag_1, din_imag_2, din_imag_3, out_ready,
        output in_ready, out_valid, out_row, out_last, done,
               dout_real_0, dout_real_1, dout_real_2, dout_real_3,
               dout_imag_0, dout_imag_1, dout_imag_2, dout_imag_3
    );
endinterface

// File: rtl/fft_4x4_2d_stream.sv
// Streaming 4x4 2D DFT (rows then columns, radix-4, no multipliers); FFT_SCALE_EN scales by 1/16 round-half-up.
// Latency: out_valid 4 cycles after the 4th row accept; output row held under out_ready=0, in_ready=0 from COL until row 3 leaves.
module fft_4x4_2d_stream #(
    parameter int DATA_W     = 16,
    parameter int COMPLEX_IN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    fft_4x4_2d_stream_if.slave io
);
    localparam int RW = DATA_W + 2;
    localparam int CW = DATA_W + 4;
`ifdef FFT_SCALE_EN
    localparam int OUT_W = DATA_W;
`else
    localparam int OUT_W = CW;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COL, S_OUT} state_t;

    state_t state, state_nxt;
    logic [1:0] row_cnt, col_cnt, out_cnt;
    logic       acc_in, acc_out, done_q;

    logic signed [RW-1:0]    rb_re [4][4], rb_im [4][4];   // [n1][k2]
    logic signed [OUT_W-1:0] cb_re [4][4], cb_im [4][4];   // [k1][k2]
    logic signed [OUT_W-1:0] do_re [4], do_im [4];

    logic signed [RW-1:0]    xr [4], xi [4], yr [4], yi [4];
    logic signed [CW-1:0]    cr [4], ci [4], zr [4], zi [4];
    logic signed [OUT_W-1:0] cs_re [4], cs_im [4];

    function automatic logic signed [OUT_W-1:0] scale(input logic signed [CW-1:0] v);
`ifdef FFT_SCALE_EN
        logic signed [CW:0] t;
        t = (CW+1)'(v) + (CW+1)'(8);
        return OUT_W'(t >>> 4);
`else
        return v;
`endif
    endfunction

    // Row DFT of the presented beat
    always_comb begin
        xr[0] = RW'(io.din_real_0);
        xr[1] = RW'(io.din_real_1);
        xr[2] = RW'(io.din_real_2);
        xr[3] = RW'(io.din_real_3);
        for (int n = 0; n < 4; n++) xi[n] = '0;
        if (COMPLEX_IN != 0) begin
            xi[0] = RW'(io.din_imag_0);
            xi[1] = RW'(io.din_imag_1);
            xi[2] = RW'(io.din_imag_2);
            xi[3] = RW'(io.din_imag_3);
        end
        yr[0] = xr[0] + xr[1] + xr[2] + xr[3];
        yi[0] = xi[0] + xi[1] + xi[2] + xi[3];
        yr[1] = (xr[0] - xr[2]) + (xi[1] - xi[3]);
        yi[1] = (xi[0] - xi[2]) - (xr[1] - xr[3]);
        yr[2] = xr[0] - xr[1] + xr[2] - xr[3];
        yi[2] = xi[0] - xi[1] + xi[2] - xi[3];
        yr[3] = (xr[0] - xr[2]) - (xi[1] - xi[3]);
        yi[3] = (xi[0] - xi[2]) + (xr[1] - xr[3]);
    end

    // Column DFT of buffered column col_cnt
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            cr[n] = CW'(rb_re[n][col_cnt]);
            ci[n] = CW'(rb_im[n][col_cnt]);
        end
        zr[0] = cr[0] + cr[1] + cr[2] + cr[3];
        zi[0] = ci[0] + ci[1] + ci[2] + ci[3];
        zr[1] = (cr[0] - cr[2]) + (ci[1] - ci[3]);
        zi[1] = (ci[0] - ci[2]) - (cr[1] - cr[3]);
        zr[2] = cr[0] - cr[1] + cr[2] - cr[3];
        zi[2] = ci[0] - ci[1] + ci[2] - ci[3];
        zr[3] = (cr[0] - cr[2]) - (ci[1] - ci[3]);
        zi[3] = (ci[0] - ci[2]) + (cr[1] - cr[3]);
        for (int k = 0; k < 4; k++) begin
            cs_re[k] = scale(zr[k]);
            cs_im[k] = scale(zi[k]);
        end
    end

    always_comb begin
        state_nxt = state;
        acc_in    = io.in_valid && (state == S_LOAD);
        acc_out   = io.out_ready && (state == S_OUT);
        case (state)
            S_IDLE:  state_nxt = S_LOAD;
            S_LOAD:  if (acc_in && row_cnt == 2'd3) state_nxt = S_COL;
            S_COL:   if (col_cnt == 2'd3) state_nxt = S_OUT;
            S_OUT:   if (acc_out && out_cnt == 2'd3) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            row_cnt <= '0;
            col_cnt <= '0;
            out_cnt <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                do_re[k] <= '0;
                do_im[k] <= '0;
            end
        end else begin
            state  <= state_nxt;
            done_q <= acc_out && (out_cnt == 2'd3);
            if (acc_in)          row_cnt <= row_cnt + 2'd1;
            if (state == S_COL)  col_cnt <= col_cnt + 2'd1;
            if (acc_out)         out_cnt <= out_cnt + 2'd1;
            // Row 0 bin 3 is produced on the same edge that enters OUT, so bypass it
            if (state == S_COL && col_cnt == 2'd3) begin
                for (int k = 0; k < 3; k++) begin
                    do_re[k] <= cb_re[0][k];
                    do_im[k] <= cb_im[0][k];
                end
                do_re[3] <= cs_re[0];
                do_im[3] <= cs_im[0];
            end else if (acc_out && out_cnt != 2'd3) begin
                for (int k = 0; k < 4; k++) begin
                    do_re[k] <= cb_re[out_cnt + 2'd1][k];
                    do_im[k] <= cb_im[out_cnt + 2'd1][k];
                end
            end
        end
    end

    // Data buffers are fully rewritten every frame, so they carry no reset
    always_ff @(posedge clk) begin
        if (acc_in) begin
            for (int k = 0; k < 4; k++) begin
                rb_re[row_cnt][k] <= yr[k];
                rb_im[row_cnt][k] <= yi[k];
            end
        end
        if (state == S_COL) begin
            for (int k = 0; k < 4; k++) begin
                cb_re[k][col_cnt] <= cs_re[k];
                cb_im[k][col_cnt] <= cs_im[k];
            end
        end
    end

    assign io.in_ready    = (state == S_LOAD);
    assign io.out_valid   = (state == S_OUT);
    assign io.out_row     = out_cnt;
    assign io.out_last    = (state == S_OUT) && (out_cnt == 2'd3);
    assign io.done        = done_q;
    assign io.dout_real_0 = do_re[0];
    assign io.dout_real_1 = do_re[1];
    assign io.dout_real_2 = do_re[2];
    assign io.dout_real_3 = do_re[3];
    assign io.dout_imag_0 = do_im[0];
    assign io.dout_imag_1 = do_im[1];
    assign io.dout_imag_2 = do_im[2];
    assign io.dout_imag_3 = do_im[3];
endmodule

// File: tb/tb_fft_4x4_2d_stream.sv
// Bench for fft_4x4_2d_stream: complex-input and real-input instances share stimulus, checked against a direct 2D DFT sum.
module tb_fft_4x4_2d_stream;
    localparam int DW = 16;
`ifdef FFT_SCALE_EN
    localparam int OW = DW;
`else
    localparam int OW = DW + 4;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fft_4x4_2d_stream_if #(.DATA_W(DW)) io0 ();
    fft_4x4_2d_stream_if #(.DATA_W(DW)) io1 ();

    fft_4x4_2d_stream #(.DATA_W(DW), .COMPLEX_IN(1)) dut_c (.clk(clk), .reset_n(reset_n), .io(io0));
    fft_4x4_2d_stream #(.DATA_W(DW), .COMPLEX_IN(0)) dut_r (.clk(clk), .reset_n(reset_n), .io(io1));

    assign io1.in_valid   = io0.in_valid;
    assign io1.out_ready  = io0.out_ready;
    assign io1.din_real_0 = io0.din_real_0;
    assign io1.din_real_1 = io0.din_real_1;
    assign io1.din_real_2 = io0.din_real_2;
    assign io1.din_real_3 = io0.din_real_3;
    assign io1.din_imag_0 = io0.din_imag_0;
    assign io1.din_imag_1 = io0.din_imag_1;
    assign io1.din_imag_2 = io0.din_imag_2;
    assign io1.din_imag_3 = io0.din_imag_3;

    logic signed [OW-1:0] ore [2][4], oim [2][4];
    always_comb begin
        ore[0][0] = io0.dout_real_0; ore[0][1] = io0.dout_real_1;
        ore[0][2] = io0.dout_real_2; ore[0][3] = io0.dout_real_3;
        oim[0][0] = io0.dout_imag_0; oim[0][1] = io0.dout_imag_1;
        oim[0][2] = io0.dout_imag_2; oim[0][3] = io0.dout_imag_3;
        ore[1][0] = io1.dout_real_0; ore[1][1] = io1.dout_real_1;
        ore[1][2] = io1.dout_real_2; ore[1][3] = io1.dout_real_3;
        oim[1][0] = io1.dout_imag_0; oim[1][1] = io1.dout_imag_1;
        oim[1][2] = io1.dout_imag_2; oim[1][3] = io1.dout_imag_3;
    end

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, done_cnt = 0, frames = 0;
    int e_acc = 0, f_first = 0, prev_first = 0;
    int fr [4][4], fi [4][4];
    longint er [2][4][4], ei [2][4][4];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (io0.done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd();
        logic signed [DW-1:0] v;
        v = DW'($urandom);
        return int'(v);
    endfunction

    // X[k1][k2] = sum x[n1][n2] * W4^(k1*n1 + k2*n2), W4 = -j
    task automatic build_model();
        longint sr, si, xr, xi;
        for (int c = 0; c < 2; c++)
            for (int k1 = 0; k1 < 4; k1++)
                for (int k2 = 0; k2 < 4; k2++) begin
                    sr = 0; si = 0;
                    for (int n1 = 0; n1 < 4; n1++)
                        for (int n2 = 0; n2 < 4; n2++) begin
                            xr = fr[n1][n2];
                            xi = (c == 0) ? longint'(fi[n1][n2]) : 0;
                            case ((k1 * n1 + k2 * n2) % 4)
                                0: begin sr += xr; si += xi; end
                                1: begin sr += xi; si -= xr; end
                                2: begin sr -= xr; si -= xi; end
                                default: begin sr -= xi; si += xr; end
                            endcase
                        end
`ifdef FFT_SCALE_EN
                    sr = (sr + 8) >>> 4;
                    si = (si + 8) >>> 4;
`endif
                    er[c][k1][k2] = sr;
                    ei[c][k1][k2] = si;
                end
    endtask

    task automatic set_row(input int r);
        io0.din_real_0 = DW'(fr[r][0]); io0.din_real_1 = DW'(fr[r][1]);
        io0.din_real_2 = DW'(fr[r][2]); io0.din_real_3 = DW'(fr[r][3]);
        io0.din_imag_0 = DW'(fi[r][0]); io0.din_imag_1 = DW'(fi[r][1]);
        io0.din_imag_2 = DW'(fi[r][2]); io0.din_imag_3 = DW'(fi[r][3]);
    endtask

    task automatic set_junk();
        io0.din_real_0 = DW'($urandom); io0.din_real_1 = DW'($urandom);
        io0.din_real_2 = DW'($urandom); io0.din_real_3 = DW'($urandom);
        io0.din_imag_0 = DW'($urandom); io0.din_imag_1 = DW'($urandom);
        io0.din_imag_2 = DW'($urandom); io0.din_imag_3 = DW'($urandom);
    endtask

    task automatic check_data(input int r, input string tag);
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 4; k++) begin
                check($sformatf("%s_d%0d_r%0d_re%0d", tag, c, r, k), ore[c][k], er[c][r][k]);
                check($sformatf("%s_d%0d_r%0d_im%0d", tag, c, r, k), oim[c][k], ei[c][r][k]);
            end
    endtask

    task automatic check_row(input int r, input string tag);
        check({tag, "_out_row"}, io0.out_row, r);
        check({tag, "_out_row_real"}, io1.out_row, r);
        check({tag, "_out_last"}, io0.out_last, (r == 3) ? 1 : 0);
        check({tag, "_in_ready"}, io0.in_ready, 0);
        check_data(r, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, io0.in_ready, 0);
        check({tag, "_out_valid"}, io0.out_valid, 0);
        check({tag, "_out_row"}, io0.out_row, 0);
        check({tag, "_out_last"}, io0.out_last, 0);
        check({tag, "_done"}, io0.done, 0);
        check({tag, "_real_in_ready"}, io1.in_ready, 0);
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 4; k++) begin
                check($sformatf("%s_d%0d_re%0d", tag, c, k), ore[c][k], 0);
                check($sformatf("%s_d%0d_im%0d", tag, c, k), oim[c][k], 0);
            end
    endtask

    // Entered with reset_n low; returns at a negedge with in_ready high
    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("rel_in_ready_before_edge", io0.in_ready, 0);
        @(posedge clk);
        #1 check("rel_in_ready_after_edge", io0.in_ready, 1);
        @(negedge clk);
    endtask

    // Called and returns at a negedge
    task automatic send_frame(input bit gaps, input bit junk);
        int k;
        build_model();
        for (int r = 0; r < 4; r++) begin
            if (gaps) begin
                io0.in_valid = 1'b0;
                set_junk();
                @(negedge clk);
            end
            set_row(r);
            io0.in_valid = 1'b1;
            k = 0;
            while (!io0.in_ready && k < 50) begin @(negedge clk); k++; end
            check("in_ready_wait", io0.in_ready, 1);
            @(posedge clk);
            #1;
            if (r == 0) f_first = cyc;
            e_acc = cyc;
            @(negedge clk);
        end
        io0.in_valid = junk;
        set_junk();
    endtask

    task automatic collect(input int stall_row, input bit chk_lat);
        int k;
        for (int r = 0; r < 4; r++) begin
            k = 0;
            while (!io0.out_valid && k < 50) begin @(negedge clk); k++; end
            check("out_valid_wait", io0.out_valid, 1);
            if (r == 0 && chk_lat) check("latency", cyc - e_acc, 4);
            check_row(r, "row");
            if (r == stall_row) begin
                io0.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_out_valid", io0.out_valid, 1);
                    check_row(r, "stall");
                end
                io0.out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("done_pulse", io0.done, 1);
        check("done_in_ready", io0.in_ready, 1);
        check("idle_out_valid", io0.out_valid, 0);
        check("idle_out_last", io0.out_last, 0);
        check_data(3, "hold");
        io0.in_valid = 1'b0;
        frames++;
    endtask

    task automatic load_ramp();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                fr[r][c] = 4 * r + c + 1;
                fi[r][c] = 0;
            end
    endtask

    task automatic load_const(input int vr, input int vi);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                fr[r][c] = vr;
                fi[r][c] = vi;
            end
    endtask

    task automatic load_random();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                fr[r][c] = rnd();
                fi[r][c] = rnd();
            end
    endtask

    initial begin
        io0.in_valid  = 1'b0;
        io0.out_ready = 1'b1;
        load_const(0, 0);
        set_row(0);

        // Reset state
        #12;
        check_reset_outputs("reset");
        release_reset();

        // Real ramp, then an immediate back-to-back random frame
        load_ramp();
        send_frame(1'b0, 1'b0);
        prev_first = f_first;
        collect(4, 1'b1);
        load_random();
        send_frame(1'b0, 1'b0);
        check("frame_period", f_first - prev_first, 12);
        collect(4, 1'b1);

        // Ramp with in_valid toggling every cycle
        load_ramp();
        send_frame(1'b1, 1'b0);
        collect(4, 1'b1);

        // Complex impulse at x[0][0]
        load_const(0, 0);
        fi[0][0] = 1;
        send_frame(1'b0, 1'b0);
        collect(4, 1'b1);

        // Extremes
        load_const(-32768, 0);
        send_frame(1'b0, 1'b0);
        collect(4, 1'b1);
        load_const(32767, 0);
        send_frame(1'b0, 1'b0);
        collect(4, 1'b1);

        // Backpressure on row 1 with in_valid held high during COL/OUT
        load_random();
        send_frame(1'b0, 1'b1);
        collect(1, 1'b1);

        // Random frames with mixed gaps, stalls and ignored in_valid
        for (int i = 0; i < 5; i++) begin
            load_random();
            send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            collect(int'($urandom_range(0, 4)), 1'b0);
        end

        // Reset while the column pass is running, then a clean ramp frame
        load_random();
        send_frame(1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midcol_reset");
        io0.in_valid = 1'b0;
        release_reset();
        load_ramp();
        send_frame(1'b0, 1'b0);
        collect(4, 1'b1);

        repeat (2) @(negedge clk);
        check("done_count", done_cnt, frames);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
